servo_pos_ctrl: RTL

//  Button-driven position controller feeding the servo PWM generator's 20-bit pulse-width select input.

---
 rtl/servo_pos_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/servo_pos_ctrl.sv
// servo_pos_ctrl
//   Debounced left/right/centre pushbuttons stepping a saturating 20-bit
//   servo position.
//   Optional feature macro: SERVO_AUTOREPEAT_EN.
//     Defined:   a held direction button auto-repeats (HOLD -> REPEAT).
//     Undefined: exactly one step per debounced press. The REPEAT state and
//                the repeat timer are not built.

// Per-button conditioning: 2-flop synchroniser, then the debounce counter.
module servo_pos_btn #(
   parameter int DB_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync;
   logic [1:0]    fill;
   logic [CW-1:0] cnt;
   logic          lvl;
   logic          armed;

   // synchroniser; fill[1] marks that sync[1] again holds a real sample after reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync <= '0;
         fill <= '0;
      end else begin
         sync <= {sync[0], raw};
         fill <= {fill[0], 1'b1};
      end
   end

   // level flips only after DB_CYCLES consecutive cycles of disagreement; any bounce restarts
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (sync[1] != lvl) begin
         if (cnt == CW'(DB_CYCLES - 1)) begin
            lvl <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // a button held through reset stays disarmed until it has been seen released,
   // so its re-debounced level cannot fake a fresh press
   always_ff @(posedge CLK) begin
      if (RST)
         armed <= 1'b0;
      else if (fill[1] && !sync[1] && !lvl)
         armed <= 1'b1;
   end

   assign press = lvl & armed;
endmodule

module servo_pos_ctrl #(
   parameter int          DB_CYCLES  = 500000,
   parameter int          REPEAT_DLY = 25000000,
   parameter int          REPEAT_PER = 2500000,
   parameter logic [19:0] L_LIM      = 20'h06C02,
   parameter logic [19:0] R_LIM      = 20'h1D9A2,
   parameter logic [19:0] N_POS      = 20'h122D2,
   parameter logic [19:0] DELTA      = 20'h001F4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BL,
   input  logic        BR,
   input  logic        BC,
   output logic [19:0] POS,
   output logic        POS_STB,
   output logic        AT_LIM
);
   localparam int NUM_BTN = 3;
   localparam int BL_I    = 0;
   localparam int BR_I    = 1;
   localparam int BC_I    = 2;

`ifdef SERVO_AUTOREPEAT_EN
   localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;
   logic [TW-1:0] timer;
`else
   typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;
   logic unused_rpt;
   assign unused_rpt = ^{REPEAT_DLY, REPEAT_PER};
`endif

   state_t             state;
   logic [NUM_BTN-1:0] raw, press, press_q, rise;
   logic               dir;        // 0 = left, 1 = right
   logic               step_dir, held, other, go;
   logic [20:0]        sum_r;
   logic [19:0]        pos_l, pos_r, step_pos;
   logic               step_lim;

   assign raw = {BC, BR, BL};

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
         servo_pos_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
            .CLK   (CLK),
            .RST   (RST),
            .raw   (raw[i]),
            .press (press[i])
         );
      end
   endgenerate

   // press decode and clamped step targets; left is compared before subtracting so it never underflows
   always_comb begin
      rise     = press & ~press_q;
      go       = (rise[BL_I] | rise[BR_I]) & ~press[BC_I] & ~(press[BL_I] & press[BR_I]);
      step_dir = (state == IDLE) ? rise[BR_I] : dir;
      held     = dir ? press[BR_I] : press[BL_I];
      other    = dir ? press[BL_I] : press[BR_I];
      sum_r    = {1'b0, POS} + {1'b0, DELTA};
      pos_r    = (sum_r > {1'b0, R_LIM}) ? R_LIM : sum_r[19:0];
      pos_l    = ({1'b0, POS} < ({1'b0, L_LIM} + {1'b0, DELTA})) ? L_LIM : (POS - DELTA);
      step_pos = step_dir ? pos_r : pos_l;
      step_lim = (step_pos == L_LIM) || (step_pos == R_LIM);
   end

   // control FSM; POS, POS_STB and AT_LIM are registered together so they line up
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         dir     <= 1'b0;
         press_q <= '0;
         POS     <= N_POS;
         POS_STB <= 1'b0;
         AT_LIM  <= 1'b0;
`ifdef SERVO_AUTOREPEAT_EN
         timer   <= '0;
`endif
      end else begin
         press_q <= press;
         POS_STB <= 1'b0;
         case (state)
            IDLE: begin
               if (rise[BC_I]) begin
                  POS     <= N_POS;
                  POS_STB <= (POS != N_POS);
                  AT_LIM  <= (N_POS == L_LIM) || (N_POS == R_LIM);
                  state   <= WAIT_REL;
               end else if (go) begin
                  POS     <= step_pos;
                  POS_STB <= (step_pos != POS);
                  AT_LIM  <= step_lim;
                  dir     <= rise[BR_I];
                  state   <= HOLD;
`ifdef SERVO_AUTOREPEAT_EN
                  timer   <= '0;
`endif
               end
            end
            HOLD: begin
               if (rise[BC_I]) begin
                  POS     <= N_POS;
                  POS_STB <= (POS != N_POS);
                  AT_LIM  <= (N_POS == L_LIM) || (N_POS == R_LIM);
                  state   <= WAIT_REL;
               end else if (!held || other) begin
                  state   <= IDLE;
               end
`ifdef SERVO_AUTOREPEAT_EN
               else if (timer == TW'(REPEAT_DLY - 1)) begin
                  POS     <= step_pos;
                  POS_STB <= (step_pos != POS);
                  AT_LIM  <= step_lim;
                  timer   <= '0;
                  state   <= REPEAT;
               end else begin
                  timer   <= timer + 1'b1;
               end
`endif
            end
`ifdef SERVO_AUTOREPEAT_EN
            REPEAT: begin
               if (rise[BC_I]) begin
                  POS     <= N_POS;
                  POS_STB <= (POS != N_POS);
                  AT_LIM  <= (N_POS == L_LIM) || (N_POS == R_LIM);
                  state   <= WAIT_REL;
               end else if (!held || other) begin
                  state   <= IDLE;
               end else if (timer == TW'(REPEAT_PER - 1)) begin
                  POS     <= step_pos;
                  POS_STB <= (step_pos != POS);
                  AT_LIM  <= step_lim;
                  timer   <= '0;
               end else begin
                  timer   <= timer + 1'b1;
               end
            end
`endif
            WAIT_REL: begin
               if (!press[BC_I]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
